// File: rtl/bicubic_filter_core_pkg.sv
// Shared constants for the separable 4x4 bicubic filter core.
// Sum widths are sized for 8-bit pixels and 9-bit signed weights.
package bicubic_filter_core_pkg;

  localparam int PIX_W       = 8;
  localparam int COEF_W      = 9;
  localparam int FRAC_BITS   = 7;
  localparam int H_SUM_W     = 20;
  localparam int V_SUM_W     = 31;
  localparam int ROUND_CONST = 8192;
  localparam int PIX_MAX     = 255;

endpackage

// File: rtl/bicubic_filter_core_fir4_mac.sv
// fir4_mac: combinational signed 4-tap multiply-accumulate.
// Operands are sign-extended to the sum width, so the sum is exact as long as SUM_W covers it.
module fir4_mac #(
  parameter int DATA_W = 9,
  parameter int COEF_W = 9,
  parameter int SUM_W  = 20
) (
  input  logic signed [DATA_W-1:0] i_d0,
  input  logic signed [DATA_W-1:0] i_d1,
  input  logic signed [DATA_W-1:0] i_d2,
  input  logic signed [DATA_W-1:0] i_d3,
  input  logic signed [COEF_W-1:0] i_c0,
  input  logic signed [COEF_W-1:0] i_c1,
  input  logic signed [COEF_W-1:0] i_c2,
  input  logic signed [COEF_W-1:0] i_c3,
  output logic signed [SUM_W-1:0]  o_sum
);

  assign o_sum = SUM_W'(i_d0) * SUM_W'(i_c0)
               + SUM_W'(i_d1) * SUM_W'(i_c1)
               + SUM_W'(i_d2) * SUM_W'(i_c2)
               + SUM_W'(i_d3) * SUM_W'(i_c3);

endmodule

// File: rtl/bicubic_filter_core.sv
// Separable 4x4 bicubic filter: column-fed pixel window, 2-stage pipeline, clamped 8-bit output.
// Define BICUBIC_ROUND_EN for round-half-up normalisation; otherwise the result is floored.
module bicubic_filter_core #(
  parameter int PIX_W     = bicubic_filter_core_pkg::PIX_W,
  parameter int COEF_W    = bicubic_filter_core_pkg::COEF_W,
  parameter int FRAC_BITS = bicubic_filter_core_pkg::FRAC_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_window,
  input  logic [PIX_W-1:0]  row0_in,
  input  logic [PIX_W-1:0]  row1_in,
  input  logic [PIX_W-1:0]  row2_in,
  input  logic [PIX_W-1:0]  row3_in,
  input  logic [COEF_W-1:0] h_w0,
  input  logic [COEF_W-1:0] h_w1,
  input  logic [COEF_W-1:0] h_w2,
  input  logic [COEF_W-1:0] h_w3,
  input  logic [COEF_W-1:0] v_w0,
  input  logic [COEF_W-1:0] v_w1,
  input  logic [COEF_W-1:0] v_w2,
  input  logic [COEF_W-1:0] v_w3,
  output logic [PIX_W-1:0]  pixel_out
);
  import bicubic_filter_core_pkg::*;

  logic        [PIX_W-1:0]   r_win [4][4];
  logic signed [H_SUM_W-1:0] r_h   [4];
  logic signed [COEF_W-1:0]  r_vw  [4];

  logic        [PIX_W-1:0]   w_row_in [4];
  logic signed [COEF_W-1:0]  w_vw     [4];
  logic signed [H_SUM_W-1:0] w_h      [4];
  logic signed [V_SUM_W-1:0] w_v;
  logic signed [V_SUM_W-1:0] w_v_rnd;
  logic signed [V_SUM_W-1:0] w_shift;
  logic        [PIX_W-1:0]   w_pix;

  assign w_row_in[0] = row0_in;
  assign w_row_in[1] = row1_in;
  assign w_row_in[2] = row2_in;
  assign w_row_in[3] = row3_in;
  assign w_vw[0] = signed'(v_w0);
  assign w_vw[1] = signed'(v_w1);
  assign w_vw[2] = signed'(v_w2);
  assign w_vw[3] = signed'(v_w3);

  // Pixels are unsigned, so a zero MSB is prepended before the signed MAC.
  for (genvar r = 0; r < 4; r++) begin : g_hrow
    fir4_mac #(.DATA_W(PIX_W + 1), .COEF_W(COEF_W), .SUM_W(H_SUM_W)) u_h (
      .i_d0  (signed'({1'b0, r_win[r][0]})),
      .i_d1  (signed'({1'b0, r_win[r][1]})),
      .i_d2  (signed'({1'b0, r_win[r][2]})),
      .i_d3  (signed'({1'b0, r_win[r][3]})),
      .i_c0  (signed'(h_w0)),
      .i_c1  (signed'(h_w1)),
      .i_c2  (signed'(h_w2)),
      .i_c3  (signed'(h_w3)),
      .o_sum (w_h[r])
    );
  end

  fir4_mac #(.DATA_W(H_SUM_W), .COEF_W(COEF_W), .SUM_W(V_SUM_W)) u_v (
    .i_d0  (r_h[0]),
    .i_d1  (r_h[1]),
    .i_d2  (r_h[2]),
    .i_d3  (r_h[3]),
    .i_c0  (r_vw[0]),
    .i_c1  (r_vw[1]),
    .i_c2  (r_vw[2]),
    .i_c3  (r_vw[3]),
    .o_sum (w_v)
  );

`ifdef BICUBIC_ROUND_EN
  assign w_v_rnd = w_v + V_SUM_W'(ROUND_CONST);
`else
  assign w_v_rnd = w_v;
`endif
  assign w_shift = w_v_rnd >>> (2 * FRAC_BITS);

  // NOTE: w_pix gets a default first so no path through the block leaves it unassigned (no latch).
  always_comb begin
    w_pix = w_shift[PIX_W-1:0];
    if (w_shift[V_SUM_W-1])
      w_pix = '0;
    else if (w_shift > V_SUM_W'(PIX_MAX))
      w_pix = PIX_W'(PIX_MAX);
  end

  // NOTE: the window is a small register array rather than RAM, so reset clears it;
  // otherwise stale pixels from before reset would reappear in the first outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) r_win[r][c] <= '0;
        r_h[r]  <= '0;
        r_vw[r] <= '0;
      end
      pixel_out <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage sample its pre-edge inputs,
      // so the window shift and both pipeline stages stay one edge apart.
      if (shift_window) begin
        for (int r = 0; r < 4; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
          r_win[r][2] <= r_win[r][3];
          r_win[r][3] <= w_row_in[r];
        end
      end
      for (int r = 0; r < 4; r++) begin
        r_h[r]  <= w_h[r];
        r_vw[r] <= w_vw[r];
      end
      pixel_out <= w_pix;
    end
  end

endmodule

// File: tb/tb_bicubic_filter_core.sv
// Self-checking bench for bicubic_filter_core: reference model feeds a scoreboard queue,
// plus direct checks of the hand-derived values for identity, average, clamp, rounding and hold.
module tb_bicubic_filter_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       shift_window = 1'b0;
  logic [7:0] row_in [4];
  logic signed [8:0] hw [4];
  logic signed [8:0] vw [4];
  logic [7:0] pixel_out;

  int m_win [4][4];
  int q [$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bicubic_filter_core dut (
    .clk          (clk),
    .rst          (rst),
    .shift_window (shift_window),
    .row0_in      (row_in[0]),
    .row1_in      (row_in[1]),
    .row2_in      (row_in[2]),
    .row3_in      (row_in[3]),
    .h_w0         (hw[0]),
    .h_w1         (hw[1]),
    .h_w2         (hw[2]),
    .h_w3         (hw[3]),
    .v_w0         (vw[0]),
    .v_w1         (vw[1]),
    .v_w2         (vw[2]),
    .v_w3         (vw[3]),
    .pixel_out    (pixel_out)
  );

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
  endtask

  function automatic int model();
    longint v = 0;
    for (int r = 0; r < 4; r++) begin
      longint h = 0;
      for (int k = 0; k < 4; k++) h += longint'(hw[k]) * longint'(m_win[r][k]);
      v += longint'(vw[r]) * h;
    end
`ifdef BICUBIC_ROUND_EN
    v += 8192;
`endif
    v = v >>> 14;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return int'(v);
  endfunction

  task automatic set_w(input int h0, input int h1, input int h2, input int h3,
                       input int v0, input int v1, input int v2, input int v3);
    hw[0] = 9'(h0); hw[1] = 9'(h1); hw[2] = 9'(h2); hw[3] = 9'(h3);
    vw[0] = 9'(v0); vw[1] = 9'(v1); vw[2] = 9'(v2); vw[3] = 9'(v3);
  endtask

  // One clock: drive at negedge, push the model result, compare the result due after this edge.
  task automatic step(input logic sh, input int r0, input int r1, input int r2, input int r3);
    @(negedge clk);
    rst = 1'b0;
    shift_window = sh;
    row_in[0] = 8'(r0); row_in[1] = 8'(r1); row_in[2] = 8'(r2); row_in[3] = 8'(r3);
    q.push_back(model());
    @(posedge clk);
    if (sh) begin
      m_win[0][0:2] = m_win[0][1:3]; m_win[0][3] = r0;
      m_win[1][0:2] = m_win[1][1:3]; m_win[1][3] = r1;
      m_win[2][0:2] = m_win[2][1:3]; m_win[2][3] = r2;
      m_win[3][0:2] = m_win[3][1:3]; m_win[3][3] = r3;
    end
    #1;
    if (q.size() >= 2) check("scoreboard", int'(pixel_out), q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    shift_window = 1'b1;
    row_in[0] = 8'd77; row_in[1] = 8'd88; row_in[2] = 8'd99; row_in[3] = 8'd111;
    @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m_win[r][c] = 0;
    check("reset_pixel", int'(pixel_out), 0);
    q.delete();
    q.push_back(0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) row_in[i] = '0;
    set_w(0, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m_win[r][c] = 0;
    do_reset();

    // Fill with nonzero data, reset mid-stream, confirm everything in flight is gone.
    set_w(32, 32, 32, 32, 32, 32, 32, 32);
    for (int i = 0; i < 4; i++) step(1'b1, 200, 150, 180, 220);
    do_reset();
    set_w(0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0);
    check("reset_zero_w", int'(pixel_out), 0);
    step(1'b0, 0, 0, 0, 0);
    check("reset_zero_w2", int'(pixel_out), 0);
    set_w(32, 32, 32, 32, 32, 32, 32, 32);
    step(1'b0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0);
    check("reset_win_clr", int'(pixel_out), 0);

    // Identity: picks win[1][1].
    set_w(0, 128, 0, 0, 0, 128, 0, 0);
    step(1'b1, 0, 10, 0, 0);
    step(1'b1, 0, 20, 0, 0);
    step(1'b1, 0, 30, 0, 0);
    step(1'b1, 0, 40, 0, 0);
    step(1'b0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0);
    check("identity", int'(pixel_out), 20);

    // Clamp low, then clamp high.
    set_w(-64, 0, 0, 192, 128, 0, 0, 0);
    step(1'b1, 255, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0);
    check("clamp_low", int'(pixel_out), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 0, 0);
    step(1'b1, 255, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0);
    check("clamp_high", int'(pixel_out), 255);

    // Rounding: V = 24576 is exactly 1.5 after the shift.
    set_w(64, 64, 0, 0, 128, 0, 0, 0);
    step(1'b1, 1, 0, 0, 0);
    step(1'b1, 2, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0);
`ifdef BICUBIC_ROUND_EN
    check("rounding", int'(pixel_out), 2);
`else
    check("rounding", int'(pixel_out), 1);
`endif

    // Average.
    set_w(32, 32, 32, 32, 32, 32, 32, 32);
    for (int i = 0; i < 4; i++) step(1'b1, 100, 100, 100, 100);
    step(1'b0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0);
    check("average", int'(pixel_out), 100);

    // Hold: toggling inputs with shift low must not disturb the output.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i % 2) ? 255 : 3, 17 * i, 200 - i, 9);
      check("hold", int'(pixel_out), 100);
    end

    // One-cycle horizontal weight change affects exactly one output, two edges later.
    set_w(64, 0, 0, 0, 32, 32, 32, 32);
    step(1'b0, 1, 2, 3, 4);
    check("phase_e0", int'(pixel_out), 100);
    set_w(32, 32, 32, 32, 32, 32, 32, 32);
    step(1'b0, 5, 6, 7, 8);
    check("phase_e1", int'(pixel_out), 50);
    step(1'b0, 9, 10, 11, 12);
    check("phase_e2", int'(pixel_out), 100);

    // Mixed signed weights on varied data, scoreboard only.
    set_w(-9, 111, 29, -3, -9, 111, 29, -3);
    for (int i = 0; i < 6; i++)
      step(1'b1, $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
    set_w(-100, 255, -50, 20, 255, -20, 10, -5);
    for (int i = 0; i < 6; i++)
      step(i != 3, $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
    step(1'b0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bicubic_filter_core.md
# bicubic_filter_core

Single-channel separable 4x4 bicubic interpolation datapath. It holds a 4-row by 4-column pixel window fed column-by-column from the line buffer. It applies a 4-tap horizontal filter per row, then a 4-tap vertical filter across the row results, and outputs one rounded, clamped 8-bit pixel. The upscaler top instantiates three copies (R, G, B) that share coefficient inputs driven from the phase-indexed coefficient ROM.

## Interface
- PIX_W, default 8: pixel width (unsigned)
- COEF_W, default 9: coefficient width (signed, two's complement)
- FRAC_BITS, default 7: fractional bits per coefficient (unity = 128)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- shift_window  in  1  shift a new column into the window
- row0_in..row3_in  in  PIX_W each  new column pixels, row0 = top
- h_w0..h_w3  in  COEF_W each signed horizontal weights, w0 applies to oldest column
- v_w0..v_w3  in  COEF_W each signed vertical weights, w0 applies to row0
- pixel_out  out  PIX_W  filtered pixel, registered

## Operation
- Window: 16 registers, win[r][c], r = 0..3, c = 0..3; c = 0 is oldest.
- On shift_window = 1, each row shifts: c0<=c1, c1<=c2, c2<=c3, c3<=rowN_in. With shift_window = 0 the window holds.
- Horizontal sum per row: H_r = sum over k of h_wk * win[r][k].
  - Pixel is zero-extended to signed, so each product is 18 bits.
  - H_r is 20-bit signed, full precision, with no intermediate rounding.
- Vertical sum: V = sum over r of v_wr * H_r, 31-bit signed.
- Normalisation: add 2^(2*FRAC_BITS-1) (8192) when rounding is enabled, then shift right arithmetically by 2*FRAC_BITS (14).
- Clamp: result < 0 gives 0; result > 255 gives 255; otherwise the low 8 bits.
- Weight sets are not required to sum to 128. Out-of-range results are handled by the clamp only.

## Timing
- Reset: all window registers, stage-1 registers and pixel_out go to 0 on the first rising edge with rst = 1. Reset mid-stream discards all in-flight data.
- Stage 1 (edge E): captures H_0..H_3, computed from the current window contents and h_w*, together with a copy of v_w0..v_w3.
- Stage 2 (edge E+1): pixel_out is updated from the stage-1 values.
- Latency: 2 edges from window/weights to pixel_out. A column shifted in at edge S first influences pixel_out after edge S+2.
- The pipeline runs every cycle regardless of shift_window. Weights may change every cycle (phase stepping), and each output uses the weight set present at its own stage-1 edge.
- rst has priority over shift_window.

## Configuration
- BICUBIC_ROUND_EN defined: round-half-up, i.e. add 8192 before the >>14.
- BICUBIC_ROUND_EN not defined: truncate (floor) via the arithmetic >>14 alone.
- Clamping is always present.

## Structure
- Shared package holds the constants: PIX_W, COEF_W, FRAC_BITS, H_SUM_W = 20, V_SUM_W = 31, ROUND_CONST = 8192, PIX_MAX = 255.
- Sub-module fir4_mac: a combinational signed 4-tap multiply-accumulate, parameterised by data and coefficient width.
  - Four instances for the horizontal rows.
  - One instance (wider data) for the vertical sum.
- Window and pipeline registers live in the top of the block.

## Test plan
- Reset: fill the window with nonzero data, then assert rst for one cycle. pixel_out = 0 after that edge and stays 0 with all-zero weights; window reads back 0.
- Identity: h = v = (0,128,0,0). Shift columns with row1_in = 10, 20, 30, 40 (other rows 0). pixel_out = 20 two edges after the fourth shift.
- Average: all weights 32, all row inputs 100 for 4 shifts. pixel_out = 100.
- Clamp:
  - h = (-64,0,0,192), v = (128,0,0,0), row0 columns 255, 0, 0, 0: pixel_out = 0.
  - Same weights, row0 columns 0, 0, 0, 255: pixel_out = 255.
- Rounding: h = (64,64,0,0), v = (128,0,0,0), row0 taps 1, 2, so V = 24576.
  - pixel_out = 2 with BICUBIC_ROUND_EN.
  - pixel_out = 1 without it.
- Hold/phase: shift_window = 0 while row inputs toggle gives a constant pixel_out. Changing h_w* for one cycle changes exactly one output, 2 edges later.
